// File: rtl/acc_tx_sched.sv
// acc_tx_sched: streams the accumulator to the host over the UART as one packet:
//   HDR, NBYTES data bytes (via the byte mux), XOR checksum of the data bytes.
// Ports:
//   clk, nRst              clock, async active-low reset
//   start, clear_after     packet request (idle only); acc_clear request latched with it
//   mux_data / sel         byte read back from / select driven to the accumulator mux
//   busy_tx / transmit     UART busy handshake / one-cycle send strobe
//   data_tx                byte for the UART, held from the strobe through WAIT_HI
//   acc_clear, done        one-cycle pulses at packet end (acc_clear one cycle first)
//   active, timeout        packet in flight / sticky no-busy error
module acc_tx_sched #(
  parameter int         NBYTES    = 16,
  parameter logic [7:0] HDR       = 8'hA5,
  parameter bit         LSB_FIRST = 1'b1,
  parameter int         BUSY_TO   = 255
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic       clear_after,
  input  logic [7:0] mux_data,
  input  logic       busy_tx,
  output logic [3:0] sel,
  output logic       transmit,
  output logic [7:0] data_tx,
  output logic       acc_clear,
  output logic       active,
  output logic       done,
  output logic       timeout
);

  localparam logic [3:0] SEL_FIRST = LSB_FIRST ? 4'd0 : 4'(NBYTES - 1);
  localparam logic [3:0] SEL_LAST  = LSB_FIRST ? 4'(NBYTES - 1) : 4'd0;
  // counter only has to reach BUSY_TO-1
  localparam int CW = (BUSY_TO > 2) ? $clog2(BUSY_TO) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_DATA, S_WAIT_HI, S_WAIT_LO, S_SETTLE, S_CSUM, S_CLR, S_FIN
  } state_t;

  typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_CSUM} phase_t;

  state_t        r_state, w_next;
  phase_t        r_phase;
  logic [3:0]    r_sel;
  logic [7:0]    r_csum;
  logic [7:0]    r_txbyte;
  logic [CW-1:0] r_cnt;
  logic          r_clr;
  logic          r_timeout;

  logic          w_tx, w_clr, w_done, w_to_hit, w_last;
  logic [7:0]    w_byte;

  // WAIT_HI lasts at most BUSY_TO cycles: the counter is 0 on the first one
  assign w_to_hit = (r_cnt == CW'(BUSY_TO - 1));
  assign w_last   = (r_sel == SEL_LAST);

  always_comb begin
    w_next = r_state;
    w_tx   = 1'b0;
    w_byte = 8'h00;
    w_clr  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_HDR;
      S_HDR:     begin w_tx = 1'b1; w_byte = HDR;      w_next = S_WAIT_HI; end
      S_DATA:    begin w_tx = 1'b1; w_byte = mux_data; w_next = S_WAIT_HI; end
      S_CSUM:    begin w_tx = 1'b1; w_byte = r_csum;   w_next = S_WAIT_HI; end
      S_WAIT_HI: begin
        w_byte = r_txbyte;
        if (busy_tx)       w_next = S_WAIT_LO;
        else if (w_to_hit) w_next = S_FIN;
      end
      S_WAIT_LO: begin
        if (!busy_tx) begin
          case (r_phase)
            PH_HDR:  w_next = S_DATA;
            PH_DATA: w_next = w_last ? S_CSUM : S_SETTLE;
            default: w_next = S_CLR;
          endcase
        end
      end
      // mux_data follows the new sel one cycle late
      S_SETTLE:  w_next = S_DATA;
      S_CLR:     begin w_clr = r_clr; w_next = S_FIN; end
      S_FIN:     begin w_done = 1'b1; w_next = S_IDLE; end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= S_IDLE;
      r_phase   <= PH_HDR;
      r_sel     <= SEL_FIRST;
      r_csum    <= 8'h00;
      r_txbyte  <= 8'h00;
      r_cnt     <= '0;
      r_clr     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_WAIT_HI) ? r_cnt + CW'(1) : '0;
      if (w_tx) r_txbyte <= w_byte;
      case (r_state)
        S_IDLE: if (start) begin
          r_clr     <= clear_after;
          r_csum    <= 8'h00;
          r_timeout <= 1'b0;
          r_sel     <= SEL_FIRST;
        end
        S_HDR:     r_phase <= PH_HDR;
        S_DATA:    begin r_phase <= PH_DATA; r_csum <= r_csum ^ mux_data; end
        S_CSUM:    r_phase <= PH_CSUM;
        S_WAIT_HI: if (!busy_tx && w_to_hit) r_timeout <= 1'b1;
        S_WAIT_LO: if (!busy_tx && r_phase == PH_DATA && !w_last)
                     r_sel <= LSB_FIRST ? r_sel + 4'd1 : r_sel - 4'd1;
        S_FIN:     r_sel <= SEL_FIRST;
        default:   ;
      endcase
    end
  end

  assign sel       = r_sel;
  assign transmit  = w_tx;
  assign data_tx   = w_byte;
  assign acc_clear = w_clr;
  assign done      = w_done;
  assign timeout   = r_timeout;
  assign active    = (r_state != S_IDLE) && (r_state != S_FIN);

endmodule

// File: tb/tb_acc_tx_sched.sv
// Bench for acc_tx_sched: instance 0 LSB_FIRST=1, instance 1 LSB_FIRST=0.
// The reference is a packet-level model: on each accepted start it builds the
// byte list (header, data in send order, XOR) and the per-cycle checker walks it.
module tb_acc_tx_sched;
  localparam int         NB   = 16;
  localparam logic [7:0] HDRB = 8'hA5;
  localparam int         BTO  = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nRst;
  logic       start [2];
  logic       clear_after [2];
  logic [7:0] mux_data [2];
  logic       busy_tx [2];
  logic [3:0] sel [2];
  logic       transmit [2];
  logic [7:0] data_tx [2];
  logic       acc_clear [2];
  logic       active [2];
  logic       done [2];
  logic       timeout [2];

  acc_tx_sched #(.NBYTES(NB), .HDR(HDRB), .LSB_FIRST(1'b1), .BUSY_TO(BTO)) u_lsb (
    .clk(clk), .nRst(nRst), .start(start[0]), .clear_after(clear_after[0]),
    .mux_data(mux_data[0]), .busy_tx(busy_tx[0]), .sel(sel[0]), .transmit(transmit[0]),
    .data_tx(data_tx[0]), .acc_clear(acc_clear[0]), .active(active[0]), .done(done[0]),
    .timeout(timeout[0]));

  acc_tx_sched #(.NBYTES(NB), .HDR(HDRB), .LSB_FIRST(1'b0), .BUSY_TO(BTO)) u_msb (
    .clk(clk), .nRst(nRst), .start(start[1]), .clear_after(clear_after[1]),
    .mux_data(mux_data[1]), .busy_tx(busy_tx[1]), .sel(sel[1]), .transmit(transmit[1]),
    .data_tx(data_tx[1]), .acc_clear(acc_clear[1]), .active(active[1]), .done(done[1]),
    .timeout(timeout[1]));

  // accumulator byte mux
  logic [7:0] acc [2][NB];
  assign mux_data[0] = acc[0][sel[0]];
  assign mux_data[1] = acc[1][sel[1]];

  // UART: busy rises uart_dly edges after the strobe edge, stays high busy_len cycles
  int busy_len [2];
  int uart_dly [2];
  bit uart_dead [2];
  int pd [2];
  int bcnt [2];
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!nRst) begin
        busy_tx[u] <= 1'b0; pd[u] <= 0; bcnt[u] <= 0;
      end else if (transmit[u] && !uart_dead[u]) begin
        if (uart_dly[u] == 0) begin busy_tx[u] <= 1'b1; bcnt[u] <= busy_len[u]; end
        else pd[u] <= uart_dly[u];
      end else if (pd[u] != 0) begin
        pd[u] <= pd[u] - 1;
        if (pd[u] == 1) begin busy_tx[u] <= 1'b1; bcnt[u] <= busy_len[u]; end
      end else if (busy_tx[u]) begin
        if (bcnt[u] <= 1) busy_tx[u] <= 1'b0;
        else bcnt[u] <= bcnt[u] - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input int u, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0h expected %0h (cycle %0d)", u, nm, act, exp, cyc);
    end
  endtask

  // model state
  bit         m_act [2];
  bit         m_to [2];
  bit         m_clr [2];
  bit         to_hit [2];
  bit         waiting [2];
  bit         prev_tx [2];
  int         exp_i [2];
  int         wt [2];
  int         pulses [2];
  int         dones [2];
  int         clears [2];
  int         clr_cyc [2];
  int         to_rise [2];
  int         first_tx [2];
  int         pkt_done [2];
  int         tx_total [2];
  logic [7:0] last [2];
  logic [7:0] expb [2][NB+2];
  logic [3:0] expsel [2][NB];
  logic [7:0] cap [2][NB+2];

  task automatic accept(input int u);
    logic [7:0] cs;
    int idx;
    cs = 8'h00;
    expb[u][0] = HDRB;
    for (int i = 0; i < NB; i++) begin
      idx = (u == 0) ? i : NB - 1 - i;
      expsel[u][i] = 4'(idx);
      expb[u][i+1] = acc[u][idx];
      cs = cs ^ acc[u][idx];
    end
    expb[u][NB+1] = cs;
    m_clr[u] = clear_after[u]; m_to[u] = 1'b0; to_hit[u] = 1'b0; waiting[u] = 1'b0;
    exp_i[u] = 0; pulses[u] = 0; dones[u] = 0; clears[u] = 0; to_rise[u] = -1;
    first_tx[u] = -1; m_act[u] = 1'b1;
  endtask

  task automatic step(input int u);
    logic [3:0] first;
    first = (u == 0) ? 4'd0 : 4'(NB - 1);
    if (!nRst) begin
      m_act[u] = 1'b0; m_to[u] = 1'b0; waiting[u] = 1'b0; prev_tx[u] = 1'b0;
      chk(u, "rst_transmit", transmit[u], 0);
      chk(u, "rst_active", active[u], 0);
      chk(u, "rst_done_clr_to", {done[u], acc_clear[u], timeout[u]}, 0);
      chk(u, "rst_data_tx", data_tx[u], 0);
      chk(u, "rst_sel", sel[u], first);
      return;
    end
    if (transmit[u]) tx_total[u]++;
    if (!m_act[u]) begin
      chk(u, "idle_transmit", transmit[u], 0);
      chk(u, "idle_active", active[u], 0);
      chk(u, "idle_done_clr", {done[u], acc_clear[u]}, 0);
      chk(u, "idle_sel", sel[u], first);
      chk(u, "idle_timeout", timeout[u], m_to[u]);
      prev_tx[u] = 1'b0;
      if (start[u]) accept(u);
      return;
    end
    if (transmit[u]) begin
      chk(u, "tx_while_busy", busy_tx[u], 0);
      chk(u, "tx_back_to_back", prev_tx[u], 0);
      chk(u, "tx_active", active[u], 1);
      chk(u, "tx_in_packet", exp_i[u] < NB + 2, 1);
      if (exp_i[u] < NB + 2) begin
        chk(u, "data_tx", data_tx[u], expb[u][exp_i[u]]);
        cap[u][exp_i[u]] = data_tx[u];
        if (exp_i[u] >= 1 && exp_i[u] <= NB)
          chk(u, "sel", sel[u], expsel[u][exp_i[u]-1]);
      end
      if (first_tx[u] < 0) first_tx[u] = cyc;
      exp_i[u]++; pulses[u]++;
      last[u] = data_tx[u]; waiting[u] = 1'b1; wt[u] = 0;
    end else if (waiting[u]) begin
      wt[u]++;
      if (wt[u] == BTO + 1) begin
        waiting[u] = 1'b0; to_hit[u] = 1'b1; m_to[u] = 1'b1;
        chk(u, "timeout_done", done[u], 1);
      end else begin
        chk(u, "data_tx_hold", data_tx[u], last[u]);
        if (busy_tx[u]) waiting[u] = 1'b0;
      end
    end
    prev_tx[u] = transmit[u];
    chk(u, "timeout", timeout[u], m_to[u]);
    if (timeout[u] && to_rise[u] < 0) to_rise[u] = cyc;
    if (acc_clear[u]) begin
      chk(u, "acc_clear_allowed", m_clr[u] && !to_hit[u] && exp_i[u] == NB + 2, 1);
      clears[u]++; clr_cyc[u] = cyc;
    end
    if (done[u]) begin
      if (!to_hit[u]) chk(u, "done_all_bytes", exp_i[u], NB + 2);
      chk(u, "clears_at_done", clears[u], (m_clr[u] && !to_hit[u]) ? 1 : 0);
      if (clears[u] > 0) chk(u, "clear_before_done", cyc - clr_cyc[u], 1);
      dones[u]++; pkt_done[u]++; m_act[u] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int u = 0; u < 2; u++) step(u);
    end
  end

  // driver helpers
  task automatic set_acc(input int u, input int mode);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < NB; k++) begin
      acc[u][k] = (mode == 0) ? 8'(k + 1) : 8'($urandom);
      if (k < NB - 1) x = x ^ acc[u][k];
    end
    if (mode == 2) acc[u][NB-1] = x ^ HDRB;  // checksum lands exactly on HDR
  endtask

  task automatic send(input int u, input bit clr);
    @(posedge clk); #1;
    start[u] = 1'b1; clear_after[u] = clr;
    @(posedge clk); #1;
    start[u] = 1'b0; clear_after[u] = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int n0, n;
    n0 = pkt_done[u]; n = 0;
    while (pkt_done[u] == n0 && n < 5000) begin @(negedge clk); n++; end
    chk(u, "done_seen", pkt_done[u] != n0, 1);
  endtask

  task automatic wait_pulses(input int u, input int p);
    int n;
    n = 0;
    while (pulses[u] < p && n < 5000) begin @(negedge clk); n++; end
    chk(u, "pulses_reached", pulses[u] >= p, 1);
  endtask

  int txb;

  initial begin
    nRst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; clear_after[u] = 1'b0; uart_dead[u] = 1'b0;
      busy_len[u] = 2; uart_dly[u] = 0; tx_total[u] = 0; pkt_done[u] = 0;
      set_acc(u, 0);
    end
    repeat (3) @(negedge clk);
    chk(0, "lit_reset_sel0", sel[0], 0);
    chk(1, "lit_reset_sel1", sel[1], 15);
    @(posedge clk); #1 nRst = 1'b1;

    // basic packet, LSB first, no clear
    send(0, 1'b0); wait_done(0);
    chk(0, "lit_pulses", pulses[0], 18);
    chk(0, "lit_hdr", cap[0][0], 8'hA5);
    chk(0, "lit_b0", cap[0][1], 8'h01);
    chk(0, "lit_b15", cap[0][16], 8'h10);
    chk(0, "lit_csum", cap[0][17], 8'h10);
    chk(0, "lit_clears", clears[0], 0);
    chk(0, "lit_dones", dones[0], 1);

    // MSB first with clear
    send(1, 1'b1); wait_done(1);
    chk(1, "lit_b0_msb", cap[1][1], 8'h10);
    chk(1, "lit_b1_msb", cap[1][2], 8'h0F);
    chk(1, "lit_b15_msb", cap[1][16], 8'h01);
    chk(1, "lit_csum_msb", cap[1][17], 8'h10);
    chk(1, "lit_clears_msb", clears[1], 1);

    // busy interlock: long busy, delayed rise
    busy_len[0] = 40; uart_dly[0] = 3; set_acc(0, 1);
    send(0, 1'b1); wait_done(0);
    chk(0, "lit_pulses_slow", pulses[0], 18);
    busy_len[0] = 2; uart_dly[0] = 0;

    // timeout after header
    uart_dead[0] = 1'b1;
    send(0, 1'b1); wait_done(0);
    chk(0, "lit_to_flag", timeout[0], 1);
    chk(0, "lit_to_pulses", pulses[0], 1);
    chk(0, "lit_to_clears", clears[0], 0);
    chk(0, "lit_to_delay", to_rise[0] - first_tx[0], BTO + 1);
    uart_dead[0] = 1'b0;
    send(0, 1'b1);
    @(negedge clk);
    chk(0, "lit_to_cleared", timeout[0], 0);
    wait_done(0);
    chk(0, "lit_after_to_pulses", pulses[0], 18);

    // start while active is dropped; following packet restarts checksum
    set_acc(1, 0);
    send(1, 1'b0); wait_pulses(1, 6);
    send(1, 1'b1); wait_done(1);
    chk(1, "lit_ign_pulses", pulses[1], 18);
    chk(1, "lit_ign_clears", clears[1], 0);
    repeat (30) @(negedge clk);
    chk(1, "lit_ign_no_restart", active[1], 0);
    send(1, 1'b0); wait_done(1);
    chk(1, "lit_fresh_csum", cap[1][17], 8'h10);

    // checksum equal to header goes out unchanged
    set_acc(0, 2);
    send(0, 1'b0); wait_done(0);
    chk(0, "lit_csum_eq_hdr", cap[0][17], 8'hA5);

    // reset mid-packet during byte 8
    set_acc(0, 1);
    send(0, 1'b0); wait_pulses(0, 10);
    @(posedge clk); #2 nRst = 1'b0;
    #1;
    chk(0, "lit_async_tx", transmit[0], 0);
    chk(0, "lit_async_active", active[0], 0);
    chk(0, "lit_async_data", data_tx[0], 0);
    chk(0, "lit_async_sel", sel[0], 0);
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    txb = tx_total[0];
    repeat (20) @(negedge clk);
    chk(0, "lit_no_tx_after_rst", tx_total[0] - txb, 0);
    send(0, 1'b0); wait_done(0);
    chk(0, "lit_post_rst_pulses", pulses[0], 18);

    // random packets
    for (int r = 0; r < 8; r++) begin
      int u;
      u = int'($urandom_range(0, 1));
      busy_len[u] = int'($urandom_range(1, 6));
      uart_dly[u] = int'($urandom_range(0, 3));
      set_acc(u, 1);
      send(u, 1'($urandom_range(0, 1)));
      wait_done(u);
      chk(u, "rand_pulses", pulses[u], 18);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
